// File: rtl/lfsr_sequencer_pkg.sv
// Shared types, constants and helpers for the LFSR sequencer slice.
package lfsr_sequencer_pkg;

  localparam int MAX_PIXEL_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNLOCK = 3'd1,
    ST_SEED   = 3'd2,
    ST_STOP   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_RUN    = 3'd5,
    ST_FINISH = 3'd6
  } seq_state_e;

  localparam logic [1:0] STATUS_OK    = 2'd0;
  localparam logic [1:0] STATUS_LIMIT = 2'd1;
  localparam logic [1:0] STATUS_ABORT = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/lfsr_sequencer_if.sv
// LFSR configuration port, LFSR run port and output word stream of the sequencer.
interface lfsr_sequencer_if #(
  parameter int MAX_PIXEL_BITS = lfsr_sequencer_pkg::MAX_PIXEL_BITS
);

  logic                      cfg_sel_o;
  logic                      cfg_rdy_o;
  logic [MAX_PIXEL_BITS-1:0] cfg_data_o;
  logic                      cfg_done_i;
  logic                      lfsr_en_o;
  logic [MAX_PIXEL_BITS-1:0] lfsr_data_i;
  logic                      lfsr_rdy_i;
  logic                      lfsr_done_i;
  logic                      out_valid_o;
  logic [MAX_PIXEL_BITS-1:0] out_data_o;
  logic                      out_ready_i;

  modport master (
    output cfg_sel_o, cfg_rdy_o, cfg_data_o, lfsr_en_o, out_valid_o, out_data_o,
    input  cfg_done_i, lfsr_data_i, lfsr_rdy_i, lfsr_done_i, out_ready_i
  );

  modport slave (
    input  cfg_sel_o, cfg_rdy_o, cfg_data_o, lfsr_en_o, out_valid_o, out_data_o,
    output cfg_done_i, lfsr_data_i, lfsr_rdy_i, lfsr_done_i, out_ready_i
  );

endinterface

// File: rtl/lfsr_seq_fifo.sv
// Small synchronous output buffer; a push into a full FIFO succeeds only when
// a pop happens in the same cycle.
module lfsr_seq_fifo
  import lfsr_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags and accepted push/pop decisions.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop_i && !empty_s;
    do_push_s = push_i && (!full_s || do_pop_s);
  end

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= data_i;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  assign data_o  = mem_r[rd_ptr_r[AW-1:0]];
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/lfsr_sequencer.sv
// Programs an external LFSR (unlock, seed, stop), streams its words into the
// output FIFO and reports how the run ended.
module lfsr_sequencer
  import lfsr_sequencer_pkg::*;
#(
  parameter int MAX_PIXEL_BITS = lfsr_sequencer_pkg::MAX_PIXEL_BITS,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [MAX_PIXEL_BITS-1:0] seed_i,
  input  logic [MAX_PIXEL_BITS-1:0] stop_i,
  input  logic [15:0]               max_words_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                status_o,
  output logic [15:0]               word_count_o,
  output logic                      overflow_o,
  lfsr_sequencer_if.master          bus
);

  seq_state_e                state_r;
  logic [MAX_PIXEL_BITS-1:0] seed_r;
  logic [MAX_PIXEL_BITS-1:0] stop_r;
  logic [15:0]               max_words_r;
  logic [15:0]               word_count_r;
  logic [1:0]                status_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      overflow_r;
  logic                      cfg_sel_r;
  logic                      cfg_rdy_r;
  logic [MAX_PIXEL_BITS-1:0] cfg_data_r;
  logic                      lfsr_en_r;

  logic                      cfg_ack_s;
  logic                      capture_s;
  logic [15:0]               count_next_s;
  logic                      finish_s;
  logic [1:0]                finish_status_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [MAX_PIXEL_BITS-1:0] fifo_data_s;

  // Run-exit decode; OK and LIMIT outrank a simultaneous abort.
  always_comb begin
    cfg_ack_s       = bus.cfg_done_i && !cfg_rdy_r;
    capture_s       = (state_r == ST_RUN) && bus.lfsr_rdy_i;
    count_next_s    = capture_s ? sat_inc(word_count_r) : word_count_r;
    pop_s           = !fifo_empty_s && bus.out_ready_i;
    finish_s        = 1'b0;
    finish_status_s = STATUS_OK;
    case (state_r)
      ST_LOAD: begin
        if (bus.lfsr_done_i) begin
          finish_s        = 1'b1;
          finish_status_s = STATUS_OK;
        end else if (abort_i) begin
          finish_s        = 1'b1;
          finish_status_s = STATUS_ABORT;
        end else begin
          finish_s        = 1'b0;
          finish_status_s = STATUS_OK;
        end
      end
      ST_RUN: begin
        if (bus.lfsr_done_i) begin
          finish_s        = 1'b1;
          finish_status_s = STATUS_OK;
        end else if (capture_s && (max_words_r != 16'd0) && (count_next_s == max_words_r)) begin
          finish_s        = 1'b1;
          finish_status_s = STATUS_LIMIT;
        end else if (abort_i) begin
          finish_s        = 1'b1;
          finish_status_s = STATUS_ABORT;
        end else begin
          finish_s        = 1'b0;
          finish_status_s = STATUS_OK;
        end
      end
      default: begin
        finish_s        = 1'b0;
        finish_status_s = STATUS_OK;
      end
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      seed_r       <= '0;
      stop_r       <= '0;
      max_words_r  <= 16'd0;
      word_count_r <= 16'd0;
      status_r     <= STATUS_OK;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      cfg_sel_r    <= 1'b0;
      cfg_rdy_r    <= 1'b0;
      cfg_data_r   <= '0;
      lfsr_en_r    <= 1'b0;
    end else begin
      cfg_rdy_r <= 1'b0;
      done_r    <= 1'b0;
      if (capture_s) begin
        word_count_r <= count_next_s;
      end
      if (capture_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            seed_r       <= seed_i;
            stop_r       <= stop_i;
            max_words_r  <= max_words_i;
            word_count_r <= 16'd0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b1;
            // Stop := ~current word releases an LFSR parked on its old stop value.
            cfg_rdy_r    <= 1'b1;
            cfg_sel_r    <= 1'b1;
            cfg_data_r   <= ~bus.lfsr_data_i;
            state_r      <= ST_UNLOCK;
          end
        end
        ST_UNLOCK: begin
          if (cfg_ack_s) begin
            cfg_rdy_r  <= 1'b1;
            cfg_sel_r  <= 1'b0;
            cfg_data_r <= seed_r;
            state_r    <= ST_SEED;
          end
        end
        ST_SEED: begin
          if (cfg_ack_s) begin
            cfg_rdy_r  <= 1'b1;
            cfg_sel_r  <= 1'b1;
            cfg_data_r <= stop_r;
            state_r    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cfg_ack_s) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD, ST_RUN: begin
          if (finish_s) begin
            status_r  <= finish_status_s;
            done_r    <= 1'b1;
            lfsr_en_r <= 1'b0;
            state_r   <= ST_FINISH;
          end else begin
            lfsr_en_r <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        ST_FINISH: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r    <= 1'b0;
          lfsr_en_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  lfsr_seq_fifo #(
    .WIDTH (MAX_PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (capture_s),
    .data_i  (bus.lfsr_data_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign status_o        = status_r;
  assign word_count_o    = word_count_r;
  assign overflow_o      = overflow_r;
  assign bus.cfg_sel_o   = cfg_sel_r;
  assign bus.cfg_rdy_o   = cfg_rdy_r;
  assign bus.cfg_data_o  = cfg_data_r;
  assign bus.lfsr_en_o   = lfsr_en_r;
  assign bus.out_valid_o = !fifo_empty_s;
  assign bus.out_data_o  = fifo_data_s;

endmodule
